// File: rtl/sd_block_read.sv
// SD SPI-mode CMD17 single-block read; 512 bytes MSB-first, one rd_valid strobe per byte, card-paced (no backpressure).
// Logic runs on SD_clk negedge, MISO sampled on posedge; `SD_RD_CRC16_EN enables the CRC16 data check.
module sd_block_read #(
  parameter int ADDR_BYTE_MODE = 0,
  parameter int R1_TIMEOUT     = 64,
  parameter int TOKEN_TIMEOUT  = 4096
) (
  input  logic        SD_clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        rd_req,
  input  logic [31:0] sec_addr,
  output logic        SD_cs,
  output logic        SD_datain,
  input  logic        SD_dataout,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_err,
  output logic [1:0]  rd_err_code
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_TOK  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_CRC  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [15:0] R1_LAST  = 16'(R1_TIMEOUT - 1);
  localparam logic [15:0] TOK_LAST = 16'(TOKEN_TIMEOUT - 1);

  logic [2:0]  state;
  logic [46:0] cmd_sr;
  logic [5:0]  cmd_cnt;
  logic        miso_q;
  logic        aligned;
  logic [6:0]  sh;
  logic [2:0]  bit_cnt;
  logic [2:0]  rel_cnt;
  logic [15:0] poll_cnt;
  logic [8:0]  byte_cnt;
  logic [31:0] addr_arg;
  logic [47:0] cmd_w;
  logic [7:0]  byte_nx;
  logic        byte_end;
  logic        crc_bad;

  assign addr_arg = (ADDR_BYTE_MODE != 0) ? {sec_addr[22:0], 9'd0} : sec_addr;
  assign cmd_w    = {8'h51, addr_arg, 8'hFF};
  assign byte_nx  = {sh, miso_q};
  assign byte_end = (bit_cnt == 3'd7);

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) miso_q <= 1'b1;
    else        miso_q <= SD_dataout;
  end

`ifdef SD_RD_CRC16_EN
  logic [15:0] crc_calc;
  logic [14:0] crc_rx;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(negedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_calc <= 16'h0000;
      crc_rx   <= 15'h0000;
    end else if (state == S_TOK) begin
      crc_calc <= 16'h0000;
    end else if (state == S_DATA) begin
      crc_calc <= crc_step(crc_calc, miso_q);
    end else if (state == S_CRC) begin
      crc_rx <= {crc_rx[13:0], miso_q};
    end
  end

  assign crc_bad = ({crc_rx, miso_q} != crc_calc);
`else
  assign crc_bad = 1'b0;
`endif

  // Both exits release the card with CS and MOSI high before pulsing the result.
  task automatic enter_rel(input logic [2:0] nxt, input logic [1:0] code);
    state     <= nxt;
    rel_cnt   <= 3'd0;
    SD_cs     <= 1'b1;
    SD_datain <= 1'b1;
    if (nxt == S_ERR) rd_err_code <= code;
  endtask

  always_ff @(negedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      SD_cs       <= 1'b1;
      SD_datain   <= 1'b1;
      rd_data     <= 8'h00;
      rd_valid    <= 1'b0;
      rd_busy     <= 1'b0;
      rd_done     <= 1'b0;
      rd_err      <= 1'b0;
      rd_err_code <= 2'd0;
      cmd_sr      <= '0;
      cmd_cnt     <= 6'd0;
      aligned     <= 1'b0;
      sh          <= 7'd0;
      bit_cnt     <= 3'd0;
      rel_cnt     <= 3'd0;
      poll_cnt    <= 16'd0;
      byte_cnt    <= 9'd0;
    end else begin
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_err   <= 1'b0;
      if (!init_i && state != S_IDLE && state != S_DONE && state != S_ERR) begin
        enter_rel(S_ERR, 2'd1);
      end else begin
        case (state)
          S_IDLE: begin
            if (rd_req && init_i) begin
              SD_cs       <= 1'b0;
              SD_datain   <= cmd_w[47];
              cmd_sr      <= cmd_w[46:0];
              cmd_cnt     <= 6'd47;
              rd_busy     <= 1'b1;
              rd_err_code <= 2'd0;
              state       <= S_CMD;
            end
          end
          S_CMD: begin
            if (cmd_cnt != 6'd0) begin
              SD_datain <= cmd_sr[46];
              cmd_sr    <= {cmd_sr[45:0], 1'b1};
              cmd_cnt   <= cmd_cnt - 6'd1;
            end else begin
              SD_datain <= 1'b1;
              aligned   <= 1'b0;
              bit_cnt   <= 3'd0;
              poll_cnt  <= 16'd0;
              state     <= S_R1;
            end
          end
          S_R1: begin
            if (!aligned) begin
              // R1 always starts with a 0 bit; that bit fixes byte alignment for the rest of the read.
              if (!miso_q) begin
                aligned <= 1'b1;
                sh      <= 7'd0;
                bit_cnt <= 3'd1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end) begin
                  if (poll_cnt == R1_LAST) enter_rel(S_ERR, 2'd1);
                  else                     poll_cnt <= poll_cnt + 16'd1;
                end
              end
            end else begin
              sh      <= byte_nx[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) begin
                if (byte_nx == 8'h00) begin
                  poll_cnt <= 16'd0;
                  state    <= S_TOK;
                end else begin
                  enter_rel(S_ERR, 2'd1);
                end
              end
            end
          end
          S_TOK: begin
            sh      <= byte_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
              if (byte_nx == 8'hFE) begin
                byte_cnt <= 9'd0;
                state    <= S_DATA;
              end else if (byte_nx[7:4] == 4'h0 || poll_cnt == TOK_LAST) begin
                enter_rel(S_ERR, 2'd2);
              end else begin
                poll_cnt <= poll_cnt + 16'd1;
              end
            end
          end
          S_DATA: begin
            sh      <= byte_nx[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
              rd_data  <= byte_nx;
              rd_valid <= 1'b1;
              if (byte_cnt == 9'd511) begin
                byte_cnt <= 9'd0;
                state    <= S_CRC;
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
              end
            end
          end
          S_CRC: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
              if (!byte_cnt[0]) byte_cnt <= 9'd1;
              else if (crc_bad) enter_rel(S_ERR, 2'd3);
              else              enter_rel(S_DONE, 2'd0);
            end
          end
          default: begin
            if (rel_cnt == 3'd7) begin
              rd_done <= (state == S_DONE);
              rd_err  <= (state == S_ERR);
              rd_busy <= 1'b0;
              state   <= S_IDLE;
            end else begin
              rel_cnt <= rel_cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

endmodule
